// File: rtl/loader_pkg.sv
// Shared types and helpers for the program loader: FSM state encoding,
// default frame marker and the running-checksum step.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RELEASE,
    RUN
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Loads a framed byte-stream program image into machine RAM, holding the CPU
// in reset until the image checksum verifies, and reloads when the CPU halts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE, CPU held in reset
// LEN     | next byte is the image length (0 = full address space)
// DATA    | image bytes, each written to RAM the following cycle
// CSUM    | next byte is compared against the accumulated checksum
// RELEASE | image good, CPU still in reset for RST_CYCLES cycles
// RUN     | CPU running; a SYNC_BYTE while halted starts a reload
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [7:0]        SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              cpu_halted,
  output logic              cpu_reset,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              loaded,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        csum;
  logic [RC_W-1:0]   rst_cnt;
  logic              xfer;
  logic [CNT_W-1:0]  len_count;

  always_comb begin
    rx_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE, LEN, DATA, CSUM: rx_ready = 1'b1;
        RUN:                   rx_ready = cpu_halted;
        default:               rx_ready = 1'b0;
      endcase
    end
  end

  assign xfer = rx_valid && rx_ready;

  // A length byte of zero stands for the whole address space.
  always_comb begin
    len_count = CNT_W'(rx_data);
    if (rx_data == 8'd0) len_count = CNT_W'(1) << ADDR_W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      loaded    <= 1'b0;
      error     <= 1'b0;
      remaining <= '0;
      ptr       <= '0;
      csum      <= '0;
      rst_cnt   <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && rx_data == SYNC_BYTE) begin
            state <= LEN;
            error <= 1'b0;
          end
        end
        LEN: begin
          if (xfer) begin
            remaining <= len_count;
            ptr       <= BASE_ADDR;
            csum      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            ram_we    <= 1'b1;
            ram_addr  <= ptr;
            ram_wdata <= rx_data;
            ptr       <= ptr + 1'b1;
            csum      <= csum_add(csum, rx_data);
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state   <= RELEASE;
              rst_cnt <= RC_W'(RST_CYCLES);
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
        end
        RELEASE: begin
          // The RELEASE state itself is the RST_CYCLES-long reset window.
          if (rst_cnt <= RC_W'(1)) begin
            rst_cnt   <= '0;
            state     <= RUN;
            cpu_reset <= 1'b0;
            loaded    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          if (xfer && rx_data == SYNC_BYTE) begin
            state     <= LEN;
            cpu_reset <= 1'b1;
            loaded    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (base 0 / base FE,
// different release lengths) share one randomized frame stream.
module tb_program_loader;

  localparam logic [7:0] BASE1 = 8'hFE;
  localparam int RST0 = 4;
  localparam int RST1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic cpu_halted = 1'b0;

  logic rdy0, crst0, we0, ld0, err0;
  logic [7:0] addr0, wd0;
  logic rdy1, crst1, we1, ld1, err1;
  logic [7:0] addr1, wd1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  bit running = 1'b0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(8), .SYNC_BYTE(8'h55), .BASE_ADDR(8'h00), .RST_CYCLES(RST0)) dut0 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rdy0),
    .cpu_halted(cpu_halted), .cpu_reset(crst0), .ram_we(we0), .ram_addr(addr0),
    .ram_wdata(wd0), .loaded(ld0), .error(err0));

  program_loader #(.ADDR_W(8), .SYNC_BYTE(8'h55), .BASE_ADDR(BASE1), .RST_CYCLES(RST1)) dut1 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rdy1),
    .cpu_halted(cpu_halted), .cpu_reset(crst1), .ram_we(we1), .ram_addr(addr1),
    .ram_wdata(wd1), .loaded(ld1), .error(err1));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM write must be the next expected (addr,data).
  always @(negedge clk) begin
    logic [15:0] e;
    if (we0) begin
      if (exp0.size() == 0) chk("dut0 unexpected write", int'({addr0, wd0}), -1);
      else begin
        e = exp0.pop_front();
        chk("dut0 write", int'({addr0, wd0}), int'(e));
      end
    end
    if (we1) begin
      if (exp1.size() == 0) chk("dut1 unexpected write", int'({addr1, wd1}), -1);
      else begin
        e = exp1.pop_front();
        chk("dut1 write", int'({addr1, wd1}), int'(e));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    guard = 0;
    if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
    while (!(rdy0 && rdy1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!(rdy0 && rdy1)) begin
      chk("send_byte rx_ready wait", int'(rdy0 && rdy1), 1);
      return;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // csum_in < 0 sends the correct checksum.
  task automatic send_frame(input logic [7:0] data[$], input logic [7:0] pre[$],
                            input bit stall, input int csum_in);
    logic [7:0] sum, cs;
    int c0, c1;
    bit dn0, dn1, bad;
    sum = 8'h00;
    for (int i = 0; i < data.size(); i++) begin
      sum = sum + data[i];
      exp0.push_back({8'(i), data[i]});
      exp1.push_back({8'(int'(BASE1) + i), data[i]});
    end
    cs  = (csum_in < 0) ? sum : 8'(csum_in);
    bad = (cs != sum);
    if (running) cpu_halted = 1'b1;
    foreach (pre[i]) send_byte(pre[i], stall);
    send_byte(8'h55, stall);
    if (running) begin
      chk("reload cpu_reset dut0", int'(crst0), 1);
      chk("reload cpu_reset dut1", int'(crst1), 1);
      chk("reload loaded dut0", int'(ld0), 0);
      chk("reload loaded dut1", int'(ld1), 0);
      cpu_halted = 1'b0;
      running = 1'b0;
    end
    chk("sync clears error", int'(err0 | err1), 0);
    send_byte(8'(data.size()), stall);
    foreach (data[i]) send_byte(data[i], stall);
    send_byte(cs, stall);
    if (bad) begin
      chk("bad error dut0", int'(err0), 1);
      chk("bad error dut1", int'(err1), 1);
      chk("bad cpu_reset", int'(crst0 & crst1), 1);
      chk("bad loaded", int'(ld0 | ld1), 0);
      chk("bad back to idle", int'(rdy0 & rdy1), 1);
    end else begin
      c0 = 0; c1 = 0; dn0 = 1'b0; dn1 = 1'b0;
      for (int k = 0; k < 20 && !(dn0 && dn1); k++) begin
        if (!dn0) begin if (crst0) c0++; else dn0 = 1'b1; end
        if (!dn1) begin if (crst1) c1++; else dn1 = 1'b1; end
        if (!(dn0 && dn1)) @(negedge clk);
      end
      chk("release cycles dut0", c0, RST0);
      chk("release cycles dut1", c1, RST1);
      chk("loaded dut0", int'(ld0), 1);
      chk("loaded dut1", int'(ld1), 1);
      chk("error after good", int'(err0 | err1), 0);
      running = 1'b1;
    end
    chk("writes outstanding dut0", exp0.size(), 0);
    chk("writes outstanding dut1", exp1.size(), 0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] p[$];
    logic [7:0] g;
    int n;

    repeat (3) @(negedge clk);
    chk("reset cpu_reset", int'(crst0 & crst1), 1);
    chk("reset ram_we", int'(we0 | we1), 0);
    chk("reset ram_addr", int'(addr0 | addr1), 0);
    chk("reset ram_wdata", int'(wd0 | wd1), 0);
    chk("reset loaded/error", int'(ld0 | ld1 | err0 | err1), 0);
    chk("reset rx_ready", int'(rdy0 | rdy1), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset ram_we", int'(we0 | we1), 0);
    chk("idle rx_ready", int'(rdy0 & rdy1), 1);

    // Good load
    d = '{8'h01, 8'h02, 8'h03}; p = {};
    send_frame(d, p, 1'b0, -1);

    // Backpressure in RUN while the CPU is not halted
    cpu_halted = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("run backpressure rx_ready", int'(rdy0 | rdy1), 0);
      chk("run stays running", int'(ld0 & ld1 & ~crst0 & ~crst1), 1);
    end
    rx_valid = 1'b0;

    // Bad checksum as a reload, then a garbage-prefixed good frame
    d = '{8'hAA, 8'hBB}; p = {};
    send_frame(d, p, 1'b0, 8'h00);
    d = '{8'h7F}; p = '{8'h12, 8'h34};
    send_frame(d, p, 1'b0, -1);

    // Reload that wraps the address on the FE-based instance
    d = '{8'h01, 8'h01, 8'h01}; p = {};
    send_frame(d, p, 1'b0, -1);

    // Reset in the middle of DATA drops the in-flight byte
    cpu_halted = 1'b1;
    send_byte(8'h55, 1'b0);
    cpu_halted = 1'b0;
    running = 1'b0;
    send_byte(8'h04, 1'b0);
    g = 8'($urandom_range(0, 255));
    exp0.push_back({8'h00, g});
    exp1.push_back({BASE1, g});
    send_byte(g, 1'b0);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hC3;
    @(negedge clk);
    chk("mid-reset ram_we", int'(we0 | we1), 0);
    chk("mid-reset cpu_reset", int'(crst0 & crst1), 1);
    chk("mid-reset loaded", int'(ld0 | ld1), 0);
    rx_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("after mid-reset ram_we", int'(we0 | we1), 0);
    chk("after mid-reset idle", int'(rdy0 & rdy1), 1);
    chk("writes outstanding after reset", exp0.size() + exp1.size(), 0);
    d = {};
    for (int i = 0; i < 4; i++) d.push_back(8'($urandom_range(0, 255)));
    p = {};
    send_frame(d, p, 1'b0, -1);

    // LEN=0 means a full 256-byte image
    d = {};
    for (int i = 0; i < 256; i++) d.push_back(8'($urandom_range(0, 255)));
    send_frame(d, p, 1'b0, -1);

    // Randomized frames: stalls, garbage prefixes, bad checksums, backpressure
    for (int t = 0; t < 30; t++) begin
      if (running && $urandom_range(0, 1) == 1) begin
        cpu_halted = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
        repeat (2) begin
          @(negedge clk);
          chk("rand backpressure rx_ready", int'(rdy0 | rdy1), 0);
        end
        rx_valid = 1'b0;
      end
      d = {};
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
      p = {};
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h55) g = 8'h56;
        p.push_back(g);
      end
      if ($urandom_range(0, 3) == 0) begin
        g = 8'h00;
        foreach (d[i]) g = g + d[i];
        g = g + 8'($urandom_range(1, 255));
        send_frame(d, p, 1'($urandom_range(0, 1)), int'(g));
      end else begin
        send_frame(d, p, 1'($urandom_range(0, 1)), -1);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
